xiyiji_timer: RTL and testbench

Wash-time programmer and countdown for the washing-machine controller. It turns the debounced add, start and emergency keys into a two-digit BCD preset and counts it down once per second. It raises a done pulse and a timed alarm at expiry. Its BCD digits drive the seven-segment display driver's code1 (tens) and code2 (units) inputs directly. It sits between the key debouncers and the display stage.

---
 rtl/xiyiji_timer_if.sv | 29 ++
 rtl/xiyiji_timer.sv | 185 ++++++++++++++++++
 tb/tb_xiyiji_timer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xiyiji_timer_if.sv
// xiyiji_timer_if
// Key inputs and display/status outputs of the wash-time programmer.
//   add, start, emergency : debounced key levels from the debouncers
//   bcd_hi, bcd_lo        : tens / units BCD digits to the seven-segment driver
//   running, paused       : status levels for the RUN and PAUSE states
//   done                  : one-cycle pulse at expiry
//   alarm                 : high for the alarm window after expiry
// master: the key/display side. slave: the timer.
interface xiyiji_timer_if;
  logic       add;
  logic       start;
  logic       emergency;
  logic [3:0] bcd_hi;
  logic [3:0] bcd_lo;
  logic       running;
  logic       paused;
  logic       done;
  logic       alarm;

  modport master (
    output add, start, emergency,
    input  bcd_hi, bcd_lo, running, paused, done, alarm
  );

  modport slave (
    input  add, start, emergency,
    output bcd_hi, bcd_lo, running, paused, done, alarm
  );
endinterface

// File: rtl/xiyiji_timer.sv
// xiyiji_timer
// Two-digit BCD wash-time preset and one-second countdown.
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : xiyiji_timer_if.slave (keys in, BCD digits and status out)
// Parameters:
//   DIV       : clk cycles per one-second tick (>= 2)
//   ALARM_SEC : alarm duration in ticks (1..15)
//
// state  | meaning
// IDLE   | programming; display shows preset, add edges step it
// RUN    | counting down; display shows remain
// PAUSE  | emergency hold; tick count frozen until start with emergency low
// ALARM  | expired; display 00, alarm high for ALARM_SEC ticks or until start
module xiyiji_timer #(
  parameter int DIV       = 100,
  parameter int ALARM_SEC = 5
) (
  input  logic           clk,
  input  logic           rst,
  xiyiji_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam int             TW         = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST  = TW'(DIV - 1);
  localparam logic [3:0]     ALARM_LAST = 4'(ALARM_SEC);

  state_t        state, state_nxt;
  logic [7:0]    preset, preset_nxt;
  logic [7:0]    remain, remain_nxt;
  logic [TW-1:0] tick, tick_nxt;
  logic [3:0]    acnt, acnt_nxt;
  logic          done_nxt;
  logic [7:0]    disp_nxt;

  logic          add_prev, start_prev;
  logic          add_rise, start_rise;
  logic          tick_wrap;
  logic [7:0]    preset_inc;
  logic [7:0]    remain_dec;
  logic [3:0]    acnt_inc;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // Only ever applied to a non-zero value, so no underflow handling.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd0) begin
      r[3:0] = 4'd9;
      r[7:4] = v[7:4] - 4'd1;
    end else begin
      r[3:0] = v[3:0] - 4'd1;
    end
    return r;
  endfunction

  // Prev registers reset to 1 so a key held through reset release is not an edge.
  assign add_rise   = bus.add & ~add_prev;
  assign start_rise = bus.start & ~start_prev;
  assign tick_wrap  = (tick == TICK_LAST);
  assign preset_inc = bcd_inc(preset);
  assign remain_dec = bcd_dec(remain);
  assign acnt_inc   = acnt + 4'd1;

  always_comb begin
    state_nxt  = state;
    preset_nxt = preset;
    remain_nxt = remain;
    tick_nxt   = tick;
    acnt_nxt   = acnt;
    done_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_rise && (preset != 8'h00)) begin
          remain_nxt = preset;
          tick_nxt   = '0;
          state_nxt  = ST_RUN;
        end else if (add_rise) begin
          preset_nxt = preset_inc;
        end
      end
      ST_RUN: begin
        // Emergency wins over a same-cycle tick: no decrement, tick held.
        if (bus.emergency) begin
          state_nxt = ST_PAUSE;
        end else if (tick_wrap) begin
          tick_nxt   = '0;
          remain_nxt = remain_dec;
          if (remain_dec == 8'h00) begin
            state_nxt = ST_ALARM;
            done_nxt  = 1'b1;
            acnt_nxt  = 4'd0;
          end
        end else begin
          tick_nxt = tick + TW'(1);
        end
      end
      ST_PAUSE: begin
        // Tick count is preserved; counting resumes on the cycle after resume.
        if (start_rise && !bus.emergency) begin
          state_nxt = ST_RUN;
        end
      end
      ST_ALARM: begin
        if (start_rise) begin
          state_nxt = ST_IDLE;
          tick_nxt  = '0;
        end else if (tick_wrap) begin
          tick_nxt = '0;
          acnt_nxt = acnt_inc;
          if (acnt_inc == ALARM_LAST) begin
            state_nxt = ST_IDLE;
          end
        end else begin
          tick_nxt = tick + TW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Display follows the state being entered so the outputs stay registered
  // yet change on the same edge as the state.
  always_comb begin
    disp_nxt = 8'h00;
    unique case (state_nxt)
      ST_IDLE:  disp_nxt = preset_nxt;
      ST_RUN:   disp_nxt = remain_nxt;
      ST_PAUSE: disp_nxt = remain_nxt;
      ST_ALARM: disp_nxt = 8'h00;
      default:  disp_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      preset      <= 8'h00;
      remain      <= 8'h00;
      tick        <= '0;
      acnt        <= 4'd0;
      add_prev    <= 1'b1;
      start_prev  <= 1'b1;
      bus.bcd_hi  <= 4'd0;
      bus.bcd_lo  <= 4'd0;
      bus.running <= 1'b0;
      bus.paused  <= 1'b0;
      bus.done    <= 1'b0;
      bus.alarm   <= 1'b0;
    end else begin
      state       <= state_nxt;
      preset      <= preset_nxt;
      remain      <= remain_nxt;
      tick        <= tick_nxt;
      acnt        <= acnt_nxt;
      add_prev    <= bus.add;
      start_prev  <= bus.start;
      bus.bcd_hi  <= disp_nxt[7:4];
      bus.bcd_lo  <= disp_nxt[3:0];
      bus.running <= (state_nxt == ST_RUN);
      bus.paused  <= (state_nxt == ST_PAUSE);
      bus.done    <= done_nxt;
      bus.alarm   <= (state_nxt == ST_ALARM);
    end
  end

endmodule

// File: tb/tb_xiyiji_timer.sv
// Bench for xiyiji_timer with DIV=4, ALARM_SEC=2.
// Output vector layout: {bcd_hi, bcd_lo, running, paused, done, alarm}.
module tb_xiyiji_timer;
  localparam int DIV  = 4;
  localparam int ASEC = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ALARM = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  xiyiji_timer_if bus ();

  xiyiji_timer #(.DIV(DIV), .ALARM_SEC(ASEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] dut_vec;
  assign dut_vec = {bus.bcd_hi, bus.bcd_lo, bus.running, bus.paused, bus.done, bus.alarm};

  int checks   = 0;
  int failures = 0;

  // Reference model: time-based view. elapsed counts RUN cycles since start,
  // so the shown value is load - elapsed/DIV and expiry is at load*DIV.
  int m_mode, m_preset, m_load, m_el, m_ael;
  bit m_done, m_pa, m_ps;

  typedef struct {
    bit          a;
    bit          s;
    bit          e;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_preset = 0;
    m_load   = 0;
    m_el     = 0;
    m_ael    = 0;
    m_done   = 1'b0;
    m_pa     = 1'b1;
    m_ps     = 1'b1;
  endtask

  task automatic model_step(input bit a, input bit s, input bit e);
    bit ar, sr;
    ar     = a && !m_pa;
    sr     = s && !m_ps;
    m_pa   = a;
    m_ps   = s;
    m_done = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (sr && m_preset != 0) begin
          m_load = m_preset;
          m_el   = 0;
          m_mode = M_RUN;
        end else if (ar) begin
          m_preset = (m_preset + 1) % 100;
        end
      end
      M_RUN: begin
        if (e) m_mode = M_PAUSE;
        else begin
          m_el++;
          if (m_el == m_load * DIV) begin
            m_mode = M_ALARM;
            m_done = 1'b1;
            m_ael  = 0;
          end
        end
      end
      M_PAUSE: if (sr && !e) m_mode = M_RUN;
      default: begin
        if (sr) m_mode = M_IDLE;
        else begin
          m_ael++;
          if (m_ael == ASEC * DIV) m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  function automatic logic [11:0] model_vec();
    int d;
    case (m_mode)
      M_IDLE:  d = m_preset;
      M_RUN:   d = m_load - m_el / DIV;
      M_PAUSE: d = m_load - m_el / DIV;
      default: d = 0;
    endcase
    return {4'(d / 10), 4'(d % 10), m_mode == M_RUN, m_mode == M_PAUSE, m_done, m_mode == M_ALARM};
  endfunction

  task automatic cyc(input bit a, input bit s, input bit e, input string name);
    bus.add       = a;
    bus.start     = s;
    bus.emergency = e;
    model_step(a, s, e);
    @(posedge clk);
    #1;
    check(name, 32'(dut_vec), 32'(model_vec()));
  endtask

  task automatic do_reset(input bit a, input bit s, input bit e);
    bus.add       = a;
    bus.start     = s;
    bus.emergency = e;
    rst = 1'b1;
    #1;
    check("async_reset", 32'(dut_vec), 32'h000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic add_edges(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, "add_hi");
      cyc(1'b0, 1'b0, 1'b0, "add_lo");
    end
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      cyc(1'b0, 1'b0, 1'b0, "wait_done");
      n++;
      if (bus.done) break;
    end
  endtask

  initial begin
    int n;
    int pulses;
    bit ra, rs, re;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 12'h000};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 12'h010};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 12'h010};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 12'h020};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 12'h020};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 12'h028};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 12'h028};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 12'h028};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 12'h028};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 12'h018};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 12'h014};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 12'h014};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 12'h014};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 12'h014};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 12'h018};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 12'h018};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 12'h018};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 12'h018};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 12'h003};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 12'h001};
    tbl[20] = '{1'b0, 1'b1, 1'b0, 12'h020};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 12'h020};

    bus.add       = 1'b0;
    bus.start     = 1'b0;
    bus.emergency = 1'b0;
    model_reset();
    #2;

    // Table of vectors from reset.
    do_reset(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].a, tbl[i].s, tbl[i].e, "model");
      check($sformatf("vec%0d", i), 32'(dut_vec), 32'(tbl[i].exp));
    end

    // Preset stepping and 99 -> 00 wrap.
    do_reset(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, "idle");
    add_edges(3);
    check("preset03", 32'(dut_vec), 32'h030);
    add_edges(96);
    check("preset99", 32'(dut_vec), 32'h990);
    add_edges(1);
    check("wrap00", 32'(dut_vec), 32'h000);

    // Countdown from 10 with borrow, alarm window, return to IDLE.
    do_reset(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, "idle");
    add_edges(10);
    check("preset10", 32'(dut_vec), 32'h100);
    cyc(1'b0, 1'b1, 1'b0, "start10");
    check("run10", 32'(dut_vec), 32'h108);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, "count");
    check("borrow09", 32'(dut_vec), 32'h098);
    wait_done(60, n);
    check("done_cycle", 32'(n + 4), 32'd40);
    check("done_vec", 32'(dut_vec), 32'h003);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b0, 1'b0, "alarm");
      if (bus.done) pulses++;
    end
    check("done_once", 32'(pulses), 32'd0);
    check("alarm_last", 32'(dut_vec), 32'h001);
    cyc(1'b0, 1'b0, 1'b0, "alarm_end");
    check("idle_after_alarm", 32'(dut_vec), 32'h100);

    // Pause and resume with frozen tick.
    do_reset(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, "idle");
    add_edges(2);
    cyc(1'b0, 1'b1, 1'b0, "start02");
    cyc(1'b0, 1'b0, 1'b0, "run");
    cyc(1'b0, 1'b0, 1'b0, "run");
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, "emerg");
    check("paused02", 32'(dut_vec), 32'h024);
    cyc(1'b0, 1'b0, 1'b0, "emerg_drop");
    check("still_paused", 32'(dut_vec), 32'h024);
    cyc(1'b0, 1'b1, 1'b0, "resume");
    check("resumed", 32'(dut_vec), 32'h028);
    cyc(1'b0, 1'b0, 1'b0, "r1");
    check("resume_hold", 32'(dut_vec), 32'h028);
    cyc(1'b0, 1'b0, 1'b0, "r2");
    check("resume_dec", 32'(dut_vec), 32'h018);
    wait_done(20, n);
    check("resume_done", 32'(n + 2), 32'd6);

    // Start with preset 00 is ignored.
    do_reset(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, "idle");
    cyc(1'b0, 1'b1, 1'b0, "start00");
    check("start_zero", 32'(dut_vec), 32'h000);

    // Reset mid-RUN, then keys held high across reset release.
    cyc(1'b1, 1'b0, 1'b0, "add");
    cyc(1'b0, 1'b0, 1'b0, "idle");
    cyc(1'b0, 1'b1, 1'b0, "start01");
    cyc(1'b0, 1'b0, 1'b0, "run");
    check("mid_run", 32'(dut_vec), 32'h018);
    do_reset(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, "held");
    check("held_keys", 32'(dut_vec), 32'h000);

    // Random stimulus against the model.
    re = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset(1'b0, 1'b0, 1'b0);
      ra = ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 29) == 0) re = ~re;
      cyc(ra, rs, re, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
